// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for sram_ctrl and the sram instance it drives.
package sram_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned DEPTH_DEF      = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_ctrl.sv
// Front-end for the single-port sram: post-reset/on-demand memory clear plus a
// valid/ready request port with fixed two-edge read latency.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF
) (
    input  logic                  i_clk,
    input  logic                  rst,
    input  logic                  i_clear,
    output logic                  o_busy,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    output logic                  o_sram_write,
    output logic [DATA_WIDTH-1:0] o_sram_data,
    input  logic [DATA_WIDTH-1:0] i_sram_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
    logic                    sram_write_q, sram_write_d;
    logic [DATA_WIDTH-1:0]   sram_data_q, sram_data_d;
    logic                    rd_p_q, rd_p_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    req_fire;

    assign o_busy      = (state_q == CLEAR);
    assign o_req_ready = (state_q == IDLE) && !i_clear;
    assign req_fire    = i_req_valid && o_req_ready;

    // Sequencing of clear writes and request capture; write strobe defaults low.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sram_addr_d  = sram_addr_q;
        sram_write_d = 1'b0;
        sram_data_d  = sram_data_q;
        rd_p_d       = 1'b0;
        unique case (state_q)
            CLEAR: begin
                sram_addr_d  = cnt_q;
                sram_write_d = 1'b1;
                sram_data_d  = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            IDLE: begin
                if (i_clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (req_fire) begin
                    sram_addr_d  = i_req_addr;
                    sram_write_d = i_req_write;
                    sram_data_d  = i_req_data;
                    rd_p_d       = !i_req_write;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Read pipeline runs regardless of state so an in-flight read survives a clear.
    always_comb begin
        rsp_valid_d = rd_p_q;
    end

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            state_q      <= CLEAR;
            cnt_q        <= '0;
            sram_addr_q  <= '0;
            sram_write_q <= 1'b0;
            sram_data_q  <= '0;
            rd_p_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sram_addr_q  <= sram_addr_d;
            sram_write_q <= sram_write_d;
            sram_data_q  <= sram_data_d;
            rd_p_q       <= rd_p_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign o_sram_addr  = sram_addr_q;
    assign o_sram_write = sram_write_q;
    assign o_sram_data  = sram_data_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_data   = i_sram_data;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl paired with a behavioural single-port sram; checks against
// a transaction-level model (memory array, clear countdown, response queue).
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int unsigned AW        = ADDR_WIDTH_DEF;
    localparam int unsigned DW        = DATA_WIDTH_DEF;
    localparam int unsigned DEPTH     = DEPTH_DEF;
    localparam int unsigned MEM_WORDS = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_clear;
    logic          o_busy;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_write;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_req_data;
    logic          o_rsp_valid;
    logic [DW-1:0] o_rsp_data;
    logic [AW-1:0] o_sram_addr;
    logic          o_sram_write;
    logic [DW-1:0] o_sram_data;
    logic [DW-1:0] sram_rdata;
    logic          scramble;

    always #5 clk = ~clk;

    sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .rst(rst), .i_clear(i_clear), .o_busy(o_busy),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_sram_addr(o_sram_addr), .o_sram_write(o_sram_write),
        .o_sram_data(o_sram_data), .i_sram_data(sram_rdata)
    );

    // Behavioural sram: synchronous write and registered read; scramble fills garbage.
    logic [DW-1:0] mem [MEM_WORDS];
    always_ff @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= $urandom;
        end else if (o_sram_write) begin
            mem[o_sram_addr] <= o_sram_data;
        end
        sram_rdata <= mem[o_sram_addr];
    end

    typedef struct packed {
        logic          rdy;
        logic          busy;
        logic          rv;
        logic          sw;
        logic [AW-1:0] sa;
        logic [DW-1:0] rd;
        logic [DW-1:0] sd;
    } obs_t;

    typedef struct packed {
        logic          rdy;
        logic          busy;
        logic          rv;
        logic [DW-1:0] rd;
    } exp_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [31:0]   due;
    } pend_t;

    logic [DW-1:0] ref_mem [DEPTH];
    pend_t         exp_q [$];
    int unsigned   clear_left;
    int unsigned   ncyc;
    int            n_tests;
    int            n_fail;

    // One clock of stimulus; returns DUT observation and the model's expectation.
    task automatic cycle(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic clr,
                         output obs_t o, output exp_t e);
        i_req_valid = v;
        i_req_write = w;
        i_req_addr  = a;
        i_req_data  = d;
        i_clear     = clr;
        @(negedge clk);
        o = '{rdy: o_req_ready, busy: o_busy, rv: o_rsp_valid, sw: o_sram_write,
              sa: o_sram_addr, rd: o_rsp_data, sd: o_sram_data};
        e.busy = (clear_left != 0);
        e.rdy  = !e.busy && !clr;
        e.rv   = 1'b0;
        e.rd   = '0;
        if (exp_q.size() != 0 && exp_q[0].due == ncyc) begin
            e.rv = 1'b1;
            e.rd = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        if (v && e.rdy) begin
            if (w) ref_mem[a] = d;
            else   exp_q.push_back('{data: ref_mem[a], due: ncyc + 2});
        end
        if (clear_left != 0) begin
            clear_left--;
        end else if (clr) begin
            clear_left = DEPTH;
            for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        end
        ncyc++;
        @(posedge clk);
        #1;
        i_req_valid = 1'b0;
        i_clear     = 1'b0;
    endtask

    task automatic model_reset();
        clear_left = DEPTH;
        exp_q.delete();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    endtask

    // Watches one full clear: busy span, clear-write address order, final memory contents.
    task automatic check_clear_sequence(input string tag);
        obs_t o;
        exp_t e;
        int   busy_n = 0;
        int   next_a = 0;
        for (int n = 0; n < int'(DEPTH) + 1; n++) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b0, o, e);
            n_tests++;
            if ({o.rdy, o.busy, o.rv, (o.rv ? o.rd : DW'(0))} !== {e.rdy, e.busy, e.rv, e.rd}) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got rdy/busy/rv/data %b/%b/%b/%h want %b/%b/%b/%h",
                         tag, n, o.rdy, o.busy, o.rv, o.rd, e.rdy, e.busy, e.rv, e.rd);
            end
            if (o.busy) busy_n++;
            if (o.sw) begin
                n_tests++;
                if (o.sa !== AW'(next_a) || o.sd !== '0) begin
                    n_fail++;
                    $display("FAIL %s clear_write: got addr %0d data %h want addr %0d data 0",
                             tag, o.sa, o.sd, next_a);
                end
                next_a++;
            end
        end
        n_tests++;
        if (busy_n != int'(DEPTH)) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_n, DEPTH);
        end
        n_tests++;
        if (next_a != int'(DEPTH)) begin
            n_fail++;
            $display("FAIL %s clear_write_count: got %0d want %0d", tag, next_a, DEPTH);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            n_tests++;
            if (mem[i] !== '0) begin
                n_fail++;
                $display("FAIL %s backdoor word %0d: got %h want 0", tag, i, mem[i]);
            end
        end
    endtask

    // Issues a short request list then idles; every cycle compared, pulse count checked.
    task automatic run_reqs(input string tag, input logic [AW+DW:0] reqs [$], input int want_rsp);
        obs_t o;
        exp_t e;
        int   rsp_n = 0;
        int   total = reqs.size() + 4;
        for (int n = 0; n < total; n++) begin
            if (n < reqs.size()) begin
                logic [AW+DW:0] r;
                r = reqs[n];
                cycle(1'b1, r[AW+DW], r[AW+DW-1:DW], r[DW-1:0], 1'b0, o, e);
            end else begin
                cycle(1'b0, 1'b0, '0, '0, 1'b0, o, e);
            end
            n_tests++;
            if ({o.rdy, o.busy, o.rv, (o.rv ? o.rd : DW'(0))} !== {e.rdy, e.busy, e.rv, e.rd}) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got rdy/busy/rv/data %b/%b/%b/%h want %b/%b/%b/%h",
                         tag, n, o.rdy, o.busy, o.rv, o.rd, e.rdy, e.busy, e.rv, e.rd);
            end
            if (o.rv) rsp_n++;
        end
        n_tests++;
        if (rsp_n != want_rsp) begin
            n_fail++;
            $display("FAIL %s rsp_count: got %0d want %0d", tag, rsp_n, want_rsp);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        scramble = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        n_tests++;
        if ({o_busy, o_req_ready, o_sram_write, o_rsp_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/rdy/wr/rv %b%b%b%b want 1000",
                     o_busy, o_req_ready, o_sram_write, o_rsp_valid);
        end
        n_tests++;
        if (o_sram_addr !== '0 || o_sram_data !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr %h data %h want 0 0", o_sram_addr, o_sram_data);
        end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        scramble = 1'b0;
        model_reset();
        check_clear_sequence("post_reset");
    endtask

    task automatic test_write_read();
        logic [AW+DW:0] q [$];
        q = '{{1'b1, AW'(5), 32'hDEADBEEF}, {1'b0, AW'(5), DW'(0)}};
        run_reqs("write_read", q, 1);
    endtask

    task automatic test_back_to_back();
        logic [AW+DW:0] q [$];
        q = '{{1'b0, AW'(0), DW'(0)}, {1'b0, AW'(5), DW'(0)}, {1'b0, AW'(15), DW'(0)}};
        run_reqs("back_to_back", q, 3);
    endtask

    task automatic test_clear_vs_req();
        obs_t o;
        exp_t e;
        logic [AW+DW:0] q [$];
        cycle(1'b1, 1'b1, AW'(3), 32'h0000_1234, 1'b1, o, e);
        n_tests++;
        if (o.rdy !== 1'b0 || e.rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_vs_req ready: got %b want 0", o.rdy);
        end
        check_clear_sequence("clear_vs_req");
        q = '{{1'b0, AW'(3), DW'(0)}};
        run_reqs("clear_vs_req_read", q, 1);
    endtask

    task automatic test_clear_inflight_read();
        obs_t o;
        exp_t e;
        logic [AW+DW:0] q [$];
        cycle(1'b1, 1'b1, AW'(5), 32'hDEADBEEF, 1'b0, o, e);
        cycle(1'b1, 1'b0, AW'(5), DW'(0), 1'b0, o, e);
        cycle(1'b0, 1'b0, '0, '0, 1'b1, o, e);
        n_tests++;
        if (o.rdy !== e.rdy) begin
            n_fail++;
            $display("FAIL inflight ready: got %b want %b", o.rdy, e.rdy);
        end
        check_clear_sequence("inflight_clear");
        q = '{{1'b0, AW'(5), DW'(0)}};
        run_reqs("inflight_reread", q, 1);
    endtask

    task automatic test_reset_mid_clear();
        obs_t o;
        exp_t e;
        cycle(1'b0, 1'b0, '0, '0, 1'b1, o, e);
        for (int n = 0; n < 7; n++) cycle(1'b0, 1'b0, '0, '0, 1'b0, o, e);
        rst      = 1'b0;
        scramble = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            n_tests++;
            if (o_sram_write !== 1'b0 || o_busy !== 1'b1 || o_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_clear_reset %0d: got wr/busy/rdy %b%b%b want 010",
                         n, o_sram_write, o_busy, o_req_ready);
            end
        end
        @(posedge clk);
        #1;
        rst      = 1'b1;
        scramble = 1'b0;
        model_reset();
        check_clear_sequence("restart_clear");
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        for (int n = 0; n < 400; n++) begin
            logic clr;
            clr = ($urandom_range(0, 59) == 0);
            if (n >= 390) clr = 1'b0;
            cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), clr, o, e);
            n_tests++;
            if ({o.rdy, o.busy, o.rv, (o.rv ? o.rd : DW'(0))} !== {e.rdy, e.busy, e.rv, e.rd}) begin
                n_fail++;
                $display("FAIL random cycle %0d: got rdy/busy/rv/data %b/%b/%b/%h want %b/%b/%b/%h",
                         n, o.rdy, o.busy, o.rv, o.rd, e.rdy, e.busy, e.rv, e.rd);
            end
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        ncyc        = 0;
        rst         = 1'b0;
        scramble    = 1'b1;
        i_clear     = 1'b0;
        i_req_valid = 1'b0;
        i_req_write = 1'b0;
        i_req_addr  = '0;
        i_req_data  = '0;
        model_reset();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_clear_vs_req();
        test_clear_inflight_read();
        test_reset_mid_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
